// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state enum and constants for the UART transmit arbiter
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
// Picks the first set request strictly after last_i, wrapping around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [ID_W-1:0] cand;

  // Walk from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    valid_o = |req_i;
    idx_o   = last_i;
    cand    = last_i;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = ID_W'((int'(last_i) + off) % N_REQ);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one byte UART transmitter
// Optional busy-rise timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        err,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         grant_id,
  output logic                    idle
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              send_q, send_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              idle_q, idle_d;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic              timeout_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= ID_W'(N_REQ - 1);
      data_q  <= '0;
      send_q  <= 1'b0;
      ack_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      send_q  <= send_d;
      ack_q   <= ack_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_valid) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle early so every port comes straight from a flop.
  always_comb begin
    grant_d = grant_q;
    data_d  = data_q;
    if (state_q == IDLE && pick_valid) begin
      grant_d = pick_idx;
      for (int i = 0; i < N_REQ; i++) begin
        if (pick_idx == ID_W'(i)) data_d = req_data[BYTE_W*i +: BYTE_W];
      end
    end
    send_d = (state_d == LAUNCH);
    idle_d = (state_d == IDLE);
    ack_d  = '0;
    if (state_q == WAIT_DONE && !tx_busy) ack_d[grant_q] = 1'b1;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] err_q, err_d;

  // cnt_q equals the number of cycles elapsed since LAUNCH.
  assign timeout_hit = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LAUNCH) cnt_d = CNT_W'(1);
    else if (state_q == WAIT_BUSY && !timeout_hit) cnt_d = cnt_q + CNT_W'(1);
    err_d = '0;
    if (timeout_hit) err_d[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  assign ack      = ack_q;
  assign tx_data  = data_q;
  assign tx_send  = send_q;
  assign grant_id = grant_q;
  assign idle     = idle_q;

endmodule
